// File: rtl/ahb_apb_bridge_ctrl.sv
// ahb_apb_bridge_ctrl
//   AHB-Lite slave front end of the AHB-APB bridge. It accepts single
//   NONSEQ/SEQ transfers, decodes them onto one of three APB slaves, and runs
//   the APB SETUP/ACCESS handshake. It returns hreadyout, hresp and hrdata to
//   the AHB master. Unmapped addresses and APB timeouts get a two-cycle AHB
//   ERROR response.
// Ports
//   hclk, hresetn          clock, asynchronous active-low reset
//   hwrite/htrans/haddr    AHB address phase; hready_in is the bus ready
//   hwdata                 AHB write data (data phase)
//   hreadyout/hresp/hrdata AHB response
//   paddr/pwdata/pwrite    APB request, held between transfers
//   psel[2:0]/penable      APB select (one-hot) and enable
//   prdata/pready          APB response
// All outputs are registered. Each state writes the outputs that belong to
// the state it is entering. The APB SETUP phase (psel=1, penable=0) is
// therefore visible while the FSM sits in S_SETUP. The ACCESS phase is
// visible while it sits in S_ACCESS.
module ahb_apb_bridge_ctrl #(
  parameter int          PTIMEOUT  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hready_in,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic [2:0]  psel,
  output logic        penable,
  input  logic [31:0] prdata,
  input  logic        pready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WWAIT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] idx;
  logic       valid, mapped;
  logic       unused_htrans0;

  // htrans[0] only separates NONSEQ from SEQ. Both are handled alike here.
  assign unused_htrans0 = htrans[0];
  assign valid  = hreadyout & hready_in & htrans[1];
  assign mapped = (haddr[31:28] == BASE_ADDR[31:28]) & (haddr[27:26] != 2'b11);

  function automatic logic [2:0] onehot(input logic [1:0] i);
    onehot = 3'b001 << i;
  endfunction

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      psel      <= '0;
      penable   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (valid) begin
          hreadyout <= 1'b0;
          if (mapped) begin
            paddr  <= haddr;
            pwrite <= hwrite;
            idx    <= haddr[27:26];
            if (hwrite) begin
              state <= S_WWAIT;
            end else begin
              // Reads need no data phase, so the SETUP phase starts right away.
              psel  <= onehot(haddr[27:26]);
              state <= S_SETUP;
            end
          end else begin
            hresp <= 1'b1;
            state <= S_ERR1;
          end
        end
        S_WWAIT: begin
          // hwdata is captured together with psel. pwdata is then stable for
          // the whole SETUP phase.
          pwdata <= hwdata;
          psel   <= onehot(idx);
          state  <= S_SETUP;
        end
        S_SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            psel      <= '0;
            penable   <= 1'b0;
            hreadyout <= 1'b1;
            if (!pwrite) hrdata <= prdata;
            state     <= S_IDLE;
          end else if (cnt == 8'(PTIMEOUT - 1)) begin
            psel    <= '0;
            penable <= 1'b0;
            hresp   <= 1'b1;
            state   <= S_ERR1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_ERR1: begin
          hreadyout <= 1'b1;
          state     <= S_ERR2;
        end
        S_ERR2: begin
          // Second ERROR cycle. Anything presented now is ignored.
          hresp <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Directed testbench for ahb_apb_bridge_ctrl. Inputs are driven 1 ns after
// the rising edge. Outputs are sampled at that same point.
module tb_ahb_apb_bridge_ctrl;
  logic        hclk = 1'b0;
  logic        hresetn, hwrite, hready_in, pready;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata, prdata;
  logic        hreadyout, hresp, pwrite, penable;
  logic [31:0] hrdata, paddr, pwdata;
  logic [2:0]  psel;
  int tests = 0, fails = 0;

  ahb_apb_bridge_ctrl #(.PTIMEOUT(16), .BASE_ADDR(32'h8000_0000)) dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hready_in(hready_in),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .paddr(paddr), .pwdata(pwdata),
    .pwrite(pwrite), .psel(psel), .penable(penable), .prdata(prdata),
    .pready(pready));

  always #5 hclk = ~hclk;

  task automatic tick;
    @(posedge hclk); #1;
  endtask

  task automatic start(input logic [31:0] a, input logic w);
    haddr = a; hwrite = w; htrans = 2'd2; hready_in = 1'b1;
  endtask

  task automatic test_reset;
    tests++; if (hreadyout !== 1'b1) begin fails++; $display("FAIL rst_hreadyout: got %b exp 1", hreadyout); end
    tests++; if (hresp !== 1'b0) begin fails++; $display("FAIL rst_hresp: got %b exp 0", hresp); end
    tests++; if (hrdata !== 32'h0) begin fails++; $display("FAIL rst_hrdata: got %h exp 0", hrdata); end
    tests++; if ({psel, penable, pwrite} !== 5'b0) begin fails++; $display("FAIL rst_apb: got %b exp 0", {psel, penable, pwrite}); end
    tests++; if ({paddr, pwdata} !== 64'h0) begin fails++; $display("FAIL rst_addr_data: got %h exp 0", {paddr, pwdata}); end
  endtask

  task automatic test_write;
    pready = 1'b1; start(32'h8000_0000, 1'b1);
    tick;
    tests++; if (hreadyout !== 1'b0) begin fails++; $display("FAIL wr_low1: got %b exp 0", hreadyout); end
    htrans = 2'd0; hwdata = 32'h24;
    tick;
    tests++; if (psel !== 3'b001 || penable !== 1'b0) begin fails++; $display("FAIL wr_setup: got psel %b pen %b exp 001 0", psel, penable); end
    tests++; if (pwrite !== 1'b1 || paddr !== 32'h8000_0000 || pwdata !== 32'h24) begin fails++; $display("FAIL wr_req: got %b %h %h exp 1 80000000 24", pwrite, paddr, pwdata); end
    tests++; if (hreadyout !== 1'b0) begin fails++; $display("FAIL wr_low2: got %b exp 0", hreadyout); end
    tick;
    tests++; if (psel !== 3'b001 || penable !== 1'b1 || hreadyout !== 1'b0) begin fails++; $display("FAIL wr_access: got %b %b %b exp 001 1 0", psel, penable, hreadyout); end
    tick;
    tests++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || psel !== 3'b0 || penable !== 1'b0) begin fails++; $display("FAIL wr_done: got %b %b %b %b exp 1 0 000 0", hreadyout, hresp, psel, penable); end
  endtask

  task automatic test_read;
    pready = 1'b1; prdata = 32'hDEAD_BEEF; start(32'h8400_0010, 1'b0);
    tick;
    tests++; if (psel !== 3'b010 || penable !== 1'b0 || hreadyout !== 1'b0) begin fails++; $display("FAIL rd_setup: got %b %b %b exp 010 0 0", psel, penable, hreadyout); end
    tests++; if (pwrite !== 1'b0 || paddr !== 32'h8400_0010) begin fails++; $display("FAIL rd_req: got %b %h exp 0 84000010", pwrite, paddr); end
    htrans = 2'd0;
    tick;
    tests++; if (penable !== 1'b1 || hreadyout !== 1'b0) begin fails++; $display("FAIL rd_access: got %b %b exp 1 0", penable, hreadyout); end
    tick;
    tests++; if (hreadyout !== 1'b1 || hrdata !== 32'hDEAD_BEEF || psel !== 3'b0) begin fails++; $display("FAIL rd_done: got %b %h %b exp 1 deadbeef 000", hreadyout, hrdata, psel); end
  endtask

  task automatic test_wait_states;
    int pen = 0, low = 1;
    pready = 1'b0; prdata = 32'h1234_5678; start(32'h8800_0000, 1'b0);
    tick;
    tests++; if (psel !== 3'b100) begin fails++; $display("FAIL ws_psel: got %b exp 100", psel); end
    htrans = 2'd0;
    for (int c = 0; c < 4; c++) begin
      tick; low++; if (penable === 1'b1 && psel === 3'b100) pen++;
    end
    pready = 1'b1;
    tick;
    tests++; if (pen != 4) begin fails++; $display("FAIL ws_penable_cycles: got %0d exp 4", pen); end
    tests++; if (low != 5 || hreadyout !== 1'b1) begin fails++; $display("FAIL ws_low_cycles: got %0d (hreadyout %b) exp 5 1", low, hreadyout); end
    tests++; if (hrdata !== 32'h1234_5678 || penable !== 1'b0) begin fails++; $display("FAIL ws_data: got %h %b exp 12345678 0", hrdata, penable); end
  endtask

  task automatic test_timeout;
    int n = 0;
    pready = 1'b0; start(32'h8000_0100, 1'b1);
    tick; htrans = 2'd0; hwdata = 32'hA5;
    tick; tick;
    while (penable === 1'b1 && n < 40) begin n++; tick; end
    tests++; if (n != 16) begin fails++; $display("FAIL to_access_cycles: got %0d exp 16", n); end
    tests++; if (psel !== 3'b0 || hresp !== 1'b1 || hreadyout !== 1'b0) begin fails++; $display("FAIL to_err1: got %b %b %b exp 000 1 0", psel, hresp, hreadyout); end
    tick;
    tests++; if (hresp !== 1'b1 || hreadyout !== 1'b1) begin fails++; $display("FAIL to_err2: got %b %b exp 1 1", hresp, hreadyout); end
    tick;
    tests++; if (hresp !== 1'b0 || hreadyout !== 1'b1 || hrdata !== 32'h1234_5678) begin fails++; $display("FAIL to_end: got %b %b %h exp 0 1 12345678", hresp, hreadyout, hrdata); end
    pready = 1'b1;
  endtask

  task automatic test_unmapped;
    logic [31:0] bad [2] = '{32'h9000_0000, 32'h8C00_0000};
    int sel = 0;
    for (int i = 0; i < 2; i++) begin
      start(bad[i], 1'b0);
      tick; sel |= psel;
      htrans = 2'd0;
      tests++; if (hresp !== 1'b1 || hreadyout !== 1'b0) begin fails++; $display("FAIL um_err1[%0d]: got %b %b exp 1 0", i, hresp, hreadyout); end
      tick; sel |= psel;
      tests++; if (hresp !== 1'b1 || hreadyout !== 1'b1) begin fails++; $display("FAIL um_err2[%0d]: got %b %b exp 1 1", i, hresp, hreadyout); end
      if (i == 1) begin
        // A valid transfer offered during the second ERROR cycle is dropped.
        prdata = 32'hCAFE_0001; start(32'h8000_0000, 1'b0);
      end
      tick; sel |= psel;
      tests++; if (hresp !== 1'b0 || hreadyout !== 1'b1) begin fails++; $display("FAIL um_end[%0d]: got %b %b exp 0 1", i, hresp, hreadyout); end
    end
    tests++; if (sel != 0) begin fails++; $display("FAIL um_psel: got %b exp 000", 3'(sel)); end
    tests++; if (hrdata !== 32'h1234_5678) begin fails++; $display("FAIL um_hrdata: got %h exp 12345678", hrdata); end
    tick;
    tests++; if (psel !== 3'b001 || hreadyout !== 1'b0) begin fails++; $display("FAIL err2_retry: got %b %b exp 001 0", psel, hreadyout); end
    htrans = 2'd0;
    tick; tick;
    tests++; if (hreadyout !== 1'b1 || hrdata !== 32'hCAFE_0001) begin fails++; $display("FAIL err2_retry_done: got %b %h exp 1 cafe0001", hreadyout, hrdata); end
  endtask

  task automatic test_back_to_back;
    start(32'h8000_0008, 1'b1);
    tick; htrans = 2'd0; hwdata = 32'h77;
    tick; tick; tick;
    tests++; if (hreadyout !== 1'b1) begin fails++; $display("FAIL b2b_wr_done: got %b exp 1", hreadyout); end
    prdata = 32'h0BAD_F00D; start(32'h8400_0000, 1'b0);
    tick;
    tests++; if (psel !== 3'b010 || hreadyout !== 1'b0) begin fails++; $display("FAIL b2b_rd_accept: got %b %b exp 010 0", psel, hreadyout); end
    htrans = 2'd0;
    tick; tick;
    tests++; if (hrdata !== 32'h0BAD_F00D || hreadyout !== 1'b1) begin fails++; $display("FAIL b2b_rd_done: got %h %b exp 0badf00d 1", hrdata, hreadyout); end
  endtask

  task automatic test_reset_mid;
    pready = 1'b0; start(32'h8000_0040, 1'b0);
    tick; htrans = 2'd0;
    tick;
    tests++; if (penable !== 1'b1) begin fails++; $display("FAIL rm_access: got %b exp 1", penable); end
    #2 hresetn = 1'b0; #1;
    tests++; if ({psel, penable, hresp, pwrite} !== 6'b0 || hreadyout !== 1'b1) begin fails++; $display("FAIL rm_async_ctl: got %b %b exp 0 1", {psel, penable, hresp, pwrite}, hreadyout); end
    tests++; if ({hrdata, paddr, pwdata} !== 96'h0) begin fails++; $display("FAIL rm_async_data: got %h exp 0", {hrdata, paddr, pwdata}); end
    @(negedge hclk); hresetn = 1'b1; pready = 1'b1;
    tick;
    start(32'h8000_0000, 1'b0); htrans = 2'd1;
    tick;
    tests++; if (hreadyout !== 1'b1 || psel !== 3'b0) begin fails++; $display("FAIL rm_busy: got %b %b exp 1 000", hreadyout, psel); end
    start(32'h8400_0004, 1'b1);
    tick; htrans = 2'd0; hwdata = 32'h55;
    tick;
    tests++; if (psel !== 3'b010 || pwdata !== 32'h55 || paddr !== 32'h8400_0004) begin fails++; $display("FAIL rm_wr_setup: got %b %h %h exp 010 55 84000004", psel, pwdata, paddr); end
    tick; tick;
    tests++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || psel !== 3'b0) begin fails++; $display("FAIL rm_wr_done: got %b %b %b exp 1 0 000", hreadyout, hresp, psel); end
  endtask

  initial begin
    hresetn = 1'b0; hwrite = 1'b0; hready_in = 1'b1; htrans = 2'd0;
    haddr = '0; hwdata = '0; prdata = '0; pready = 1'b1;
    tick; tick;
    test_reset;
    @(negedge hclk); hresetn = 1'b1;
    tick;
    test_write;
    test_read;
    test_wait_states;
    test_timeout;
    test_unmapped;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ahb_apb_bridge_ctrl.md
Name: ahb_apb_bridge_ctrl

Overview:
- AHB-Lite slave side of the AHB-APB bridge, directly downstream of the AHB master stimulus block.
- Accepts single NONSEQ/SEQ transfers and decodes them onto one of three APB slaves.
- Runs the APB SETUP/ACCESS sequence and returns hreadyout and hrdata to the master.
- Flags unmapped addresses and APB timeouts with a two-cycle AHB ERROR response.

Parameters:
PTIMEOUT, 16, maximum ACCESS cycles with pready low before the transfer is aborted (range 2..255)
BASE_ADDR, 32'h8000_0000, base of the APB region; each slave window is 64 MB (haddr[27:26] selects)

Ports:
hclk  in  1  system clock
hresetn  in  1  asynchronous active-low reset
hwrite  in  1  AHB write(1)/read(0), address phase
hready_in  in  1  AHB bus ready input
htrans  in  2  AHB transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
haddr  in  32  AHB address, address phase
hwdata  in  32  AHB write data, data phase
hreadyout  out  1  transfer complete / slave ready
hresp  out  1  0 OKAY, 1 ERROR
hrdata  out  32  read data
paddr  out  32  APB address
pwdata  out  32  APB write data
pwrite  out  1  APB direction
psel  out  3  one-hot APB slave select
penable  out  1  APB enable
prdata  in  32  APB read data
pready  in  1  APB ready

Behaviour:
- Clock and reset: single clock hclk; reset hresetn is asynchronous, active-low. Reset value of every output and internal register: hreadyout=1, hresp=0, hrdata=0, paddr=0, pwdata=0, pwrite=0, psel=0, penable=0, state=IDLE, timeout counter=0. Reset asserted mid-transfer aborts immediately: psel/penable drop, no completion is reported.
- All outputs are registered (Moore).
- valid = hreadyout & hready_in & htrans[1]. BUSY and IDLE are ignored and keep hreadyout=1.
- Address map: mapped = (haddr[31:28] == BASE_ADDR[31:28]) & (haddr[27:26] != 2'b11). Slave index = haddr[27:26].
- State IDLE (hreadyout=1, hresp=0):
  - valid & mapped: latch haddr into paddr, hwrite into pwrite, index into a slave register; hreadyout<=0. Next state WWAIT if write, SETUP if read.
  - valid & !mapped: hreadyout<=0, hresp<=1; next ERR1.
- WWAIT: pwdata<=hwdata (data phase); next SETUP.
- SETUP: psel<=onehot(index), penable<=0, counter<=0; next ACCESS.
  - pwdata captured in WWAIT is stable on entry to SETUP.
- ACCESS: penable=1.
  - pready=1: penable<=0, psel<=0, hreadyout<=1; on reads hrdata<=prdata. Next IDLE.
  - pready=0 and counter==PTIMEOUT-1: drop psel/penable, hresp<=1, hreadyout stays 0; next ERR1.
  - Otherwise counter++.
- ERR1: hreadyout<=1, hresp stays 1; next ERR2.
- ERR2: hresp<=0; next IDLE. A transfer presented in this cycle is not accepted.
- Latency from accepting edge (pready=1, no wait states):
  - Read: hreadyout low 2 cycles; hrdata valid on the edge hreadyout returns high.
  - Write: hreadyout low 3 cycles.
  - Each pready-low cycle adds one cycle.
- Back-to-back: the next transfer is accepted no earlier than the edge after hreadyout returns to 1. Address-phase signals are held by the master while hreadyout=0.
- hrdata holds its value between reads; writes and errors do not change it.
- pwrite, paddr and pwdata hold their last values in IDLE.

Test Plan:
- Write 0x8000_0000, data 0x24, pready=1 -> psel=3'b001 with pwrite=1, paddr=0x8000_0000, pwdata=0x24. Then penable=1 the next cycle. hreadyout low exactly 3 cycles, hresp=0.
- Read 0x8400_0010, prdata=0xDEAD_BEEF, pready=1 -> psel=3'b010. hreadyout low 2 cycles, hrdata=0xDEAD_BEEF when hreadyout rises.
- Read 0x8800_0000 with pready low for 3 ACCESS cycles -> psel=3'b100 and penable held 4 cycles. hreadyout low 5 cycles total.
- Write with pready stuck low, PTIMEOUT=16 -> exactly 16 ACCESS cycles. Then psel=0, followed by hresp=1/hreadyout=0 for one cycle, then hresp=1/hreadyout=1 for one cycle.
- Unmapped read 0x9000_0000 and 0x8C00_0000 -> psel never asserted. Two-cycle ERROR response; hrdata unchanged.
- hresetn low during ACCESS of a read -> all outputs at reset values asynchronously. After release, a new write completes normally; htrans=1 (BUSY) is ignored.
